drisc_bus_unit: RTL

//  Parametrised multicycle external-bus controller for the drisc core: replaces the fixed

---
 rtl/drisc_pkg.sv | 29 ++
 rtl/drisc_lane_align.sv | 49 ++++
 rtl/drisc_bus_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/drisc_pkg.sv
// Shared types for the drisc external-bus controller and its lane aligner.
package drisc_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } bus_state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_MISALIGN,
        ERR_SIZE,
        ERR_TIMEOUT
    } err_t;

    function automatic logic [3:0] size_bytes(input size_t sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/drisc_lane_align.sv
// Byte-lane steering: store data onto bus lanes, load data extraction and extension.
module drisc_lane_align
    import drisc_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OW   = $clog2(XLEN / 8)
)(
    input  size_t            st_size_i,
    input  logic [OW-1:0]    st_sub_i,
    input  logic [OW-1:0]    st_lane_i,
    input  logic [XLEN-1:0]  wdata_i,
    output logic [XLEN-1:0]  st_data_o,
    input  size_t            ld_size_i,
    input  logic             ld_unsigned_i,
    input  logic [OW-1:0]    ld_offset_i,
    input  logic [XLEN-1:0]  w0_i,
    input  logic [XLEN-1:0]  w1_i,
    output logic [XLEN-1:0]  ld_data_o
);

    function automatic logic [XLEN-1:0] size_mask(input size_t sz);
        logic [XLEN-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < XLEN / 8; i++) begin
            if (i < 32'(size_bytes(sz))) m[8*i +: 8] = 8'hFF;
        end
        return m;
    endfunction

    logic [XLEN-1:0] st_bytes;
    logic [XLEN-1:0] ld_raw;
    logic [XLEN-1:0] ld_mask;
    logic            ld_sign;

    // Split stores walk the source one byte per sub-access; aligned stores use sub 0.
    always_comb begin
        st_bytes  = (wdata_i >> {st_sub_i, 3'b000}) & size_mask(st_size_i);
        st_data_o = st_bytes << {st_lane_i, 3'b000};
    end

    // Sign bit is the top bit of the size mask, found without a variable index.
    always_comb begin
        ld_raw    = XLEN'({w1_i, w0_i} >> {ld_offset_i, 3'b000});
        ld_mask   = size_mask(ld_size_i);
        ld_sign   = ~ld_unsigned_i & (|(ld_raw & ld_mask & ~(ld_mask >> 1)));
        ld_data_o = (ld_raw & ld_mask) | (ld_sign ? ~ld_mask : '0);
    end

endmodule

// File: rtl/drisc_bus_unit.sv
// drisc external-bus controller: request/response engine with wait states, timeout
// and hardware splitting of misaligned loads and stores.
module drisc_bus_unit
    import drisc_pkg::*;
#(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned ALLOW_MISALIGNED = 1,
    parameter int unsigned MAX_WAIT         = 15,
    parameter int unsigned ADDR_CYCLES      = 1
)(
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic            req_unsigned,
    input  logic [1:0]      req_size,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic            resp_error,
    output logic [XLEN-1:0] resp_rdata,
    output logic [XLEN-1:0] address_bus,
    output logic [1:0]      data_size,
    output logic            write_address,
    output logic            read,
    output logic            write,
    output logic [XLEN-1:0] io_out,
    output logic            io_oe,
    input  logic [XLEN-1:0] io_in,
    input  logic            bus_ready
);

    localparam int unsigned NB      = XLEN / 8;
    localparam int unsigned OW      = $clog2(NB);
    localparam int unsigned WW      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int unsigned AW      = $clog2(ADDR_CYCLES + 1);
    localparam size_t       FULL_SZ = (XLEN == 64) ? SZ_D : SZ_W;

    bus_state_t      state_q, state_d;
    logic [OW-1:0]   sub_q, sub_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [AW-1:0]   acnt_q, acnt_d;
    logic [XLEN-1:0] w0_q, w0_d;
    logic [XLEN-1:0] w1_q, w1_d;
    err_t            err_q, err_d;

    logic            write_q;
    logic            unsigned_q;
    size_t           size_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            split_q;
    logic [OW-1:0]   last_q;

    size_t           req_sz;
    logic [3:0]      req_nb;
    logic [OW-1:0]   req_amask;
    logic            req_mis;
    logic            req_bad;
    logic [OW-1:0]   req_last;
    logic            accept;

    logic [XLEN-1:0] base_addr;
    logic [XLEN-1:0] cur_addr;
    size_t           cur_size;
    logic            in_bus;
    logic [XLEN-1:0] st_data;
    logic [XLEN-1:0] ld_data;

    assign req_sz    = size_t'(req_size);
    assign req_nb    = size_bytes(req_sz);
    assign req_amask = OW'(req_nb - 4'd1);
    assign req_mis   = |(req_addr[OW-1:0] & req_amask);
    assign req_bad   = (XLEN == 32) && (req_sz == SZ_D);
    assign accept    = req_valid && (state_q == IDLE);

    // Split loads fetch two full words; split stores issue one byte write per size byte.
    always_comb begin
        if (!req_mis)        req_last = '0;
        else if (!req_write) req_last = OW'(1);
        else                 req_last = OW'(req_nb - 4'd1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= SZ_B;
            addr_q     <= '0;
            wdata_q    <= '0;
            split_q    <= 1'b0;
            last_q     <= '0;
        end else if (accept) begin
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
            size_q     <= req_sz;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            split_q    <= req_mis;
            last_q     <= req_last;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sub_q   <= '0;
            wait_q  <= '0;
            acnt_q  <= '0;
            w0_q    <= '0;
            w1_q    <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            wait_q  <= wait_d;
            acnt_q  <= acnt_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        wait_d  = wait_q;
        acnt_d  = acnt_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    sub_d   = '0;
                    acnt_d  = '0;
                    wait_d  = '0;
                    w0_d    = '0;
                    w1_d    = '0;
                    err_d   = ERR_NONE;
                    state_d = ADDR;
                    if (req_bad) begin
                        err_d   = ERR_SIZE;
                        state_d = RESP;
                    end else if (req_mis && (ALLOW_MISALIGNED == 0)) begin
                        err_d   = ERR_MISALIGN;
                        state_d = RESP;
                    end
                end
            end
            ADDR: begin
                if (acnt_q == AW'(ADDR_CYCLES - 1)) begin
                    acnt_d  = '0;
                    wait_d  = '0;
                    state_d = DATA;
                end else begin
                    acnt_d = acnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bus_ready) begin
                    if (!write_q) begin
                        if (sub_q == '0) w0_d = io_in;
                        else             w1_d = io_in;
                    end
                    if (sub_q == last_q) begin
                        state_d = RESP;
                    end else begin
                        sub_d   = sub_q + 1'b1;
                        state_d = ADDR;
                    end
                end else if ((MAX_WAIT != 0) && (wait_q == WW'(MAX_WAIT - 1))) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign base_addr = {addr_q[XLEN-1:OW], {OW{1'b0}}};

    always_comb begin
        cur_addr = addr_q;
        cur_size = size_q;
        if (split_q) begin
            if (write_q) begin
                cur_addr = addr_q + XLEN'(sub_q);
                cur_size = SZ_B;
            end else begin
                cur_addr = base_addr + (XLEN'(sub_q) << OW);
                cur_size = FULL_SZ;
            end
        end
    end

    drisc_lane_align #(
        .XLEN (XLEN),
        .OW   (OW)
    ) u_lane_align (
        .st_size_i     (cur_size),
        .st_sub_i      (sub_q),
        .st_lane_i     (cur_addr[OW-1:0]),
        .wdata_i       (wdata_q),
        .st_data_o     (st_data),
        .ld_size_i     (size_q),
        .ld_unsigned_i (unsigned_q),
        .ld_offset_i   (addr_q[OW-1:0]),
        .w0_i          (w0_q),
        .w1_i          (w1_q),
        .ld_data_o     (ld_data)
    );

    // All bus outputs decode from the state register so an async reset drops them at once.
    assign in_bus        = (state_q == ADDR) || (state_q == DATA);
    assign req_ready     = (state_q == IDLE);
    assign write_address = (state_q == ADDR);
    assign read          = (state_q == DATA) && !write_q;
    assign write         = (state_q == DATA) && write_q;
    assign io_oe         = write;
    assign address_bus   = in_bus ? cur_addr : '0;
    assign data_size     = in_bus ? cur_size : SZ_B;
    assign io_out        = io_oe ? st_data : '0;
    assign resp_valid    = (state_q == RESP);
    assign resp_error    = resp_valid && (err_q != ERR_NONE);
    assign resp_rdata    = (resp_valid && (err_q == ERR_NONE) && !write_q) ? ld_data : '0;

endmodule
